// File: rtl/micro_sequencer.sv
// micro_sequencer: registered microprogram counter with branch, dispatch
// and an optional return stack enabled by macro MSEQ_STACK_EN.
module micro_sequencer #(
    parameter int AW    = 5,
    parameter int NCOND = 4,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(NCOND),
    localparam int SW   = $clog2(DEPTH + 1),
    localparam int NP   = 2 ** CW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [2:0]       seq_op,
    input  logic [AW-1:0]    naddr,
    input  logic [AW-1:0]    map_addr,
    input  logic [NCOND-1:0] cond,
    input  logic [CW-1:0]    cond_sel,
    input  logic             cond_inv,
    output logic [AW-1:0]    upc,
    output logic [SW-1:0]    sp,
    output logic             stk_err
);

    typedef enum logic [2:0] {
        OP_NEXT    = 3'b000,
        OP_JUMP    = 3'b001,
        OP_BRANCH  = 3'b010,
        OP_MAP     = 3'b011,
        OP_CALL    = 3'b100,
        OP_RET     = 3'b101,
        OP_LOOPMAP = 3'b110,
        OP_START   = 3'b111
    } seq_op_e;

    seq_op_e       op;
    logic [AW-1:0] upc_q;
    logic [AW-1:0] upc_d;
    logic [AW-1:0] inc;
    logic [NP-1:0] cond_ext;
    logic [NP-1:0] cond_ok;
    logic          t;

    assign op  = seq_op_e'(seq_op);
    assign inc = upc_q + AW'(1);

    // Selects used beyond NCOND read as a false condition, even when inverted.
    always_comb begin
        cond_ext = NP'(cond);
        cond_ok  = NP'({NCOND{1'b1}});
        t        = cond_ok[cond_sel] & (cond_ext[cond_sel] ^ cond_inv);
    end

`ifdef MSEQ_STACK_EN

    logic [SW-1:0] sp_q;
    logic [SW-1:0] sp_d;
    logic          err_q;
    logic          err_d;
    logic          push;
    logic [AW-1:0] tos;
    logic [AW-1:0] stk_q [DEPTH];

    // Top of stack is the entry just below the occupancy pointer.
    always_comb begin
        tos = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sp_q == SW'(i + 1)) begin
                tos = stk_q[i];
            end
        end
    end

    // Next-address and stack-pointer decision for the current control word.
    always_comb begin
        upc_d = inc;
        sp_d  = sp_q;
        err_d = err_q;
        push  = 1'b0;
        unique case (op)
            OP_NEXT:    upc_d = inc;
            OP_JUMP:    upc_d = naddr;
            OP_BRANCH:  upc_d = t ? naddr : inc;
            OP_MAP:     upc_d = map_addr;
            OP_CALL: begin
                upc_d = naddr;
                if (sp_q == SW'(DEPTH)) begin
                    err_d = 1'b1;
                end else begin
                    push = 1'b1;
                    sp_d = sp_q + SW'(1);
                end
            end
            OP_RET: begin
                if (sp_q == '0) begin
                    upc_d = '0;
                    err_d = 1'b1;
                end else begin
                    upc_d = tos;
                    sp_d  = sp_q - SW'(1);
                end
            end
            OP_LOOPMAP: upc_d = t ? naddr : map_addr;
            OP_START: begin
                upc_d = '0;
                sp_d  = '0;
                err_d = 1'b0;
            end
        endcase
    end

    // Return-address storage; contents are masked by sp so need no reset.
    always_ff @(posedge clk) begin
        if (!rst && !stall && push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (sp_q == SW'(i)) begin
                    stk_q[i] <= inc;
                end
            end
        end
    end

    // Sequencer state; reset wins over stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            upc_q <= '0;
            sp_q  <= '0;
            err_q <= 1'b0;
        end else if (!stall) begin
            upc_q <= upc_d;
            sp_q  <= sp_d;
            err_q <= err_d;
        end
    end

    assign sp      = sp_q;
    assign stk_err = err_q;

`else

    // Without a stack, CALL degenerates to JUMP and RET to NEXT.
    always_comb begin
        upc_d = inc;
        unique case (op)
            OP_NEXT:    upc_d = inc;
            OP_JUMP:    upc_d = naddr;
            OP_BRANCH:  upc_d = t ? naddr : inc;
            OP_MAP:     upc_d = map_addr;
            OP_CALL:    upc_d = naddr;
            OP_RET:     upc_d = inc;
            OP_LOOPMAP: upc_d = t ? naddr : map_addr;
            OP_START:   upc_d = '0;
        endcase
    end

    // Microprogram counter; reset wins over stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            upc_q <= '0;
        end else if (!stall) begin
            upc_q <= upc_d;
        end
    end

    assign sp      = '0;
    assign stk_err = 1'b0;

`endif

    assign upc = upc_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: directed vector table, corner sequences and a
// randomized run checked against a queue-based reference model.
module tb_micro_sequencer;

    localparam int AW    = 5;
    localparam int NCOND = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(NCOND);
    localparam int SW    = $clog2(DEPTH + 1);
`ifdef MSEQ_STACK_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             stall;
    logic [2:0]       seq_op;
    logic [AW-1:0]    naddr;
    logic [AW-1:0]    map_addr;
    logic [NCOND-1:0] cond;
    logic [CW-1:0]    cond_sel;
    logic             cond_inv;
    logic [AW-1:0]    upc;
    logic [SW-1:0]    sp;
    logic             stk_err;

    micro_sequencer #(.AW(AW), .NCOND(NCOND), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .stall    (stall),
        .seq_op   (seq_op),
        .naddr    (naddr),
        .map_addr (map_addr),
        .cond     (cond),
        .cond_sel (cond_sel),
        .cond_inv (cond_inv),
        .upc      (upc),
        .sp       (sp),
        .stk_err  (stk_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total;
    int n_pass;

    // Reference model state: plain integers and a queue as the stack.
    int m_upc;
    int m_stk[$];
    bit m_err;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic model_step(input int op, input int na, input int ma,
                              input logic [NCOND-1:0] c, input int sel,
                              input bit inv, input bit stl, input bit r);
        int inc;
        bit t;
        if (r) begin
            m_upc = 0;
            m_stk.delete();
            m_err = 0;
            return;
        end
        if (stl) return;
        t   = (sel < NCOND) ? (c[sel] ^ inv) : 1'b0;
        inc = (m_upc + 1) % (1 << AW);
        case (op)
            0: m_upc = inc;
            1: m_upc = na;
            2: m_upc = t ? na : inc;
            3: m_upc = ma;
            4: begin
                if (STK) begin
                    if (m_stk.size() == DEPTH) m_err = 1;
                    else m_stk.push_back(inc);
                end
                m_upc = na;
            end
            5: begin
                if (!STK) m_upc = inc;
                else if (m_stk.size() == 0) begin
                    m_upc = 0;
                    m_err = 1;
                end else m_upc = m_stk.pop_back();
            end
            6: m_upc = t ? na : ma;
            default: begin
                m_upc = 0;
                m_stk.delete();
                m_err = 0;
            end
        endcase
    endtask

    // Drive one cycle, step the model, then check after the edge.
    task automatic cyc(input int op, input int na, input int ma,
                       input logic [NCOND-1:0] c, input int sel,
                       input bit inv, input bit stl, input bit r);
        seq_op   = op[2:0];
        naddr    = na[AW-1:0];
        map_addr = ma[AW-1:0];
        cond     = c;
        cond_sel = sel[CW-1:0];
        cond_inv = inv;
        stall    = stl;
        rst      = r;
        model_step(op, na, ma, c, sel, inv, stl, r);
        @(posedge clk);
        #1;
        chk("model_upc", int'(upc), m_upc);
        chk("model_sp", int'(sp), m_stk.size());
        chk("model_err", int'(stk_err), int'(m_err));
    endtask

    task automatic expect3(input string tag, input int eu, input int es,
                           input int ee);
        chk({tag, "_upc"}, int'(upc), eu);
        chk({tag, "_sp"}, int'(sp), es);
        chk({tag, "_err"}, int'(stk_err), ee);
    endtask

    typedef struct {
        int               op;
        int               na;
        int               ma;
        logic [NCOND-1:0] c;
        int               sel;
        bit               inv;
        bit               stl;
        bit               r;
        int               eupc;
    } vec_t;

    vec_t tbl[17];

    initial begin
        int pops_stk[4];
        int pops_nstk[4];
        n_total = 0;
        n_pass  = 0;
        m_upc   = 0;
        m_err   = 0;
        rst = 1'b1; stall = 1'b0; seq_op = 3'd0; naddr = '0;
        map_addr = '0; cond = '0; cond_sel = '0; cond_inv = 1'b0;

        //           op  na  ma  cond     sel inv stl rst  upc
        tbl[0]  = '{0,  0,  0,  4'b0000, 0,  0,  0,  1,   0};
        tbl[1]  = '{3,  5,  6,  4'b0000, 0,  0,  1,  1,   0};
        tbl[2]  = '{0,  0,  0,  4'b0000, 0,  0,  0,  0,   1};
        tbl[3]  = '{0,  0,  0,  4'b0000, 0,  0,  0,  0,   2};
        tbl[4]  = '{0,  0,  0,  4'b0000, 0,  0,  0,  0,   3};
        tbl[5]  = '{1,  31, 0,  4'b0000, 0,  0,  0,  0,   31};
        tbl[6]  = '{0,  0,  0,  4'b0000, 0,  0,  0,  0,   0};
        tbl[7]  = '{2,  9,  0,  4'b0001, 0,  0,  0,  0,   9};
        tbl[8]  = '{2,  9,  0,  4'b0000, 0,  0,  0,  0,   10};
        tbl[9]  = '{2,  9,  0,  4'b0000, 0,  1,  0,  0,   9};
        tbl[10] = '{6,  11, 9,  4'b0000, 0,  0,  0,  0,   9};
        tbl[11] = '{6,  11, 9,  4'b0000, 0,  0,  0,  0,   9};
        tbl[12] = '{6,  11, 9,  4'b0001, 0,  0,  0,  0,   11};
        tbl[13] = '{3,  0,  17, 4'b0000, 0,  0,  0,  0,   17};
        tbl[14] = '{2,  3,  0,  4'b0100, 2,  0,  0,  0,   3};
        tbl[15] = '{0,  0,  0,  4'b0000, 0,  0,  1,  0,   3};
        tbl[16] = '{7,  0,  0,  4'b0000, 0,  0,  0,  0,   0};

        @(posedge clk);
        #1;
        for (int i = 0; i < 17; i++) begin
            cyc(tbl[i].op, tbl[i].na, tbl[i].ma, tbl[i].c, tbl[i].sel,
                tbl[i].inv, tbl[i].stl, tbl[i].r);
            chk($sformatf("tbl%0d_upc", i), int'(upc), tbl[i].eupc);
            chk($sformatf("tbl%0d_sp", i), int'(sp), 0);
        end

        // Call / return, overflow, drain and underflow.
        cyc(1, 4, 0, '0, 0, 0, 0, 0);
        expect3("jmp4", 4, 0, 0);
        cyc(4, 20, 0, '0, 0, 0, 0, 0);
        expect3("call20", 20, STK ? 1 : 0, 0);
        cyc(0, 0, 0, '0, 0, 0, 0, 0);
        expect3("next21", 21, STK ? 1 : 0, 0);
        cyc(5, 0, 0, '0, 0, 0, 0, 0);
        expect3("ret", STK ? 5 : 22, 0, 0);
        for (int i = 1; i <= DEPTH + 1; i++) begin
            cyc(4, 20, 0, '0, 0, 0, 0, 0);
            expect3($sformatf("fill%0d", i), 20,
                    STK ? ((i > DEPTH) ? DEPTH : i) : 0,
                    (STK && i > DEPTH) ? 1 : 0);
        end
        pops_stk  = '{21, 21, 21, 6};
        pops_nstk = '{21, 22, 23, 24};
        for (int i = 0; i < DEPTH; i++) begin
            cyc(5, 0, 0, '0, 0, 0, 0, 0);
            expect3($sformatf("pop%0d", i),
                    STK ? pops_stk[i] : pops_nstk[i],
                    STK ? DEPTH - 1 - i : 0, STK ? 1 : 0);
        end
        cyc(5, 0, 0, '0, 0, 0, 0, 0);
        expect3("ret_empty", STK ? 0 : 25, 0, STK ? 1 : 0);

        // Stall during a CALL, then reset while still stalled.
        cyc(4, 7, 0, '0, 0, 0, 0, 0);
        expect3("call7", 7, STK ? 1 : 0, STK ? 1 : 0);
        for (int i = 0; i < 3; i++) begin
            cyc(4, 25, 0, '0, 0, 0, 1, 0);
            expect3($sformatf("stall%0d", i), 7, STK ? 1 : 0, STK ? 1 : 0);
        end
        cyc(4, 25, 0, '0, 0, 0, 1, 1);
        expect3("rst_stall", 0, 0, 0);
        cyc(0, 0, 0, '0, 0, 0, 0, 0);
        expect3("resume", 1, 0, 0);

        // Randomized run against the reference model.
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(7), $urandom_range(31), $urandom_range(31),
                NCOND'($urandom), $urandom_range(NCOND - 1),
                1'($urandom), ($urandom_range(5) == 0),
                ($urandom_range(60) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/micro_sequencer.md
MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 SHALL have parameter AW, default 5, meaning microaddress width in bits.
REQ-002 SHALL have parameter NCOND, default 4, meaning the number of condition inputs (2..16).
REQ-003 SHALL have parameter DEPTH, default 4, meaning return-stack entries (1..16).
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, meaning reset; synchronous, active-high.
REQ-006 SHALL have port stall, input, 1, meaning hold all state when high.
REQ-007 SHALL have port seq_op, input, 3, meaning the sequencing operation for the current microinstruction.
REQ-008 SHALL have port naddr, input, AW, meaning the next-address field of the control word.
REQ-009 SHALL have port map_addr, input, AW, meaning the opcode-mapped dispatch address.
REQ-010 SHALL have port cond, input, NCOND, meaning the condition flags (bit 0 = Z).
REQ-011 SHALL have port cond_sel, input, clog2(NCOND), meaning the index of the tested flag.
REQ-012 SHALL have port cond_inv, input, 1, meaning invert the tested flag.
REQ-013 SHALL have port upc, output, AW, meaning the registered microprogram counter that addresses control store.
REQ-014 SHALL have port sp, output, clog2(DEPTH+1), meaning current stack occupancy.
REQ-015 SHALL have port stk_err, output, 1, meaning sticky stack overflow/underflow flag.

Function
REQ-016 SHALL define t = cond[cond_sel] XOR cond_inv; cond_sel >= NCOND gives t = 0.
REQ-017 SHALL compute inc = (upc + 1) mod 2^AW, so all-ones wraps to 0.
REQ-018 SHALL load upc on each unstalled edge per seq_op: 000 NEXT -> inc; 001 JUMP -> naddr; 010 BRANCH -> t ? naddr : inc; 011 MAP -> map_addr.
REQ-019 SHALL load upc per the remaining ops: 100 CALL -> naddr and push inc; 101 RET -> pop; 110 LOOPMAP -> t ? naddr : map_addr; 111 START -> 0 and clear sp.
REQ-020 SHALL add exactly one cycle of latency: the decision made from inputs in cycle n is visible on upc in cycle n+1.
REQ-021 SHALL, for CALL with sp == DEPTH, perform no push, still jump to naddr, and set stk_err.
REQ-022 SHALL, for RET with sp == 0, load upc = 0, leave sp at 0, and set stk_err.
REQ-023 SHALL implement the stack as LIFO: RET returns the most recently pushed, unpopped address.
REQ-024 SHALL, when stall = 1 and rst = 0, hold upc, sp, stack contents and stk_err unchanged.
REQ-025 SHALL clear stk_err only on rst or START.

Reset
REQ-026 SHALL, with rst = 1 at a rising edge, set upc = 0, sp = 0 and stk_err = 0, regardless of stall or seq_op.
REQ-027 SHALL allow stack contents to be left undefined after reset, since sp = 0 masks them.
REQ-028 SHALL, on reset asserted mid-sequence, resume from address 0 on the first edge after rst falls, with no residue of a pending CALL or RET.

Configuration
REQ-029 SHALL honour macro MSEQ_STACK_EN: when it is defined, CALL and RET behave as specified above.
REQ-030 SHALL, when MSEQ_STACK_EN is undefined, instantiate no stack storage, decode CALL as JUMP and RET as NEXT, and tie sp and stk_err to 0.

Verification
REQ-031 SHALL cover: rst = 1 for 2 cycles, then NEXT x3 -> upc = 0, 1, 2, 3.
REQ-032 SHALL cover: AW = 5, upc = 31, NEXT -> upc = 0.
REQ-033 SHALL cover: BRANCH naddr = 9, cond_sel = 0, Z = 1, cond_inv = 0 -> upc = 9; then the same with Z = 0 -> upc = 10.
REQ-034 SHALL cover: LOOPMAP naddr = 11, map_addr = 9, Z toggling 0, 0, 1 -> upc = 9, 9, 11.
REQ-035 SHALL cover: at upc = 4, CALL naddr = 20, NEXT, RET -> upc = 20, 21, 5 and sp = 1, 1, 0; then DEPTH + 1 CALLs -> sp = DEPTH and stk_err = 1, followed by RET on empty -> upc = 0.
REQ-036 SHALL cover: stall = 1 for 3 cycles during a CALL, then rst = 1 while stall = 1 -> no state change while stalled, then upc = 0, sp = 0, stk_err = 0 after the reset edge.
